ext_seq_controller: RTL and testbench

Multi-cycle sequencer for custom extension instructions: opcode 5'b00010 is the register form, 5'b01010 is the immediate form.
- Sits beside the main decoder; the decoder still handles base RV32I.
- Replaces one-cycle extension strobes with a per-channel valid/ready issue, done-wait, timeout and optional writeback.
- Stalls the pipeline (gates pcWE) while an extension operation is in flight.

---
 rtl/ext_seq_pkg.sv | 19 +
 rtl/ext_seq_controller_timer.sv | 34 +++
 rtl/ext_seq_controller.sv | 193 +++++++++++++++++++
 tb/tb_ext_seq_controller.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ext_seq_pkg.sv
// Shared opcodes, FSM state type and channel-select width for the extension sequencer.
package ext_seq_pkg;

  localparam logic [4:0] OP_EXT_R = 5'b00010;
  localparam logic [4:0] OP_EXT_I = 5'b01010;
  localparam int         SEL_W    = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    WB    = 2'd3
  } state_t;

  function automatic logic is_ext_op(input logic [4:0] op);
    return (op == OP_EXT_R) || (op == OP_EXT_I);
  endfunction

endpackage

// File: rtl/ext_seq_controller_timer.sv
// Saturating up-counter used as the issue/done timeout; terminal is high at all-ones.
module ext_seq_timer #(
  parameter int TIMEOUT_W = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic terminal
);

  logic [TIMEOUT_W-1:0] count_q, count_d;

  assign terminal = &count_q;

  // Holds at the terminal count instead of wrapping.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en && !terminal) begin
      count_d = count_q + {{(TIMEOUT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/ext_seq_controller.sv
// Multi-cycle sequencer for custom extension opcodes: issue, done-wait, timeout, writeback.
// Optional performance counters are built when EXT_SEQ_PERF_EN is defined.
module ext_seq_controller
  import ext_seq_pkg::*;
#(
  parameter int NUM_EXT   = 4,
  parameter int XLEN      = 32,
  parameter int TIMEOUT_W = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    inst_valid,
  input  logic [4:0]              opcode,
  input  logic [2:0]              funct3,
  input  logic [XLEN-1:0]         rs1_val,
  input  logic [11:0]             imm,
  output logic [NUM_EXT-1:0]      ext_req_valid,
  input  logic [NUM_EXT-1:0]      ext_req_ready,
  output logic [XLEN-1:0]         ext_arg,
  output logic [11:0]             ext_cnt,
  input  logic [NUM_EXT-1:0]      ext_done,
  input  logic [NUM_EXT*XLEN-1:0] ext_rdata,
  output logic                    stall,
  output logic                    wb_we,
  output logic [XLEN-1:0]         wb_data,
  output logic                    err,
  output logic                    busy,
  output state_t                  dbg_state
`ifdef EXT_SEQ_PERF_EN
  ,
  output logic [31:0]             perf_busy_cycles,
  output logic [15:0]             perf_timeouts
`endif
);

  state_t                  state_q, state_d;
  logic [SEL_W-1:0]        sel_q, sel_d;
  logic [XLEN-1:0]         arg_q, arg_d;
  logic [11:0]             cnt_q, cnt_d;
  logic                    need_wb_q, need_wb_d;
  logic [XLEN-1:0]         wb_data_q, wb_data_d;
  logic                    err_q, err_d;

  logic                    hit, legal;
  logic [NUM_EXT-1:0]      sel_mask;
  logic                    accept, done_sel;
  logic [NUM_EXT*XLEN-1:0] rdata_shift;
  logic                    timer_clr, timer_en, timer_term, timeout_evt;

  assign hit   = inst_valid && is_ext_op(opcode);
  assign legal = (funct3 != 3'd0) && (32'(funct3) < NUM_EXT);

  // Channel handshakes are filtered through the one-hot mask of the latched channel.
  assign sel_mask    = {{(NUM_EXT-1){1'b0}}, 1'b1} << sel_q;
  assign accept      = |(ext_req_ready & sel_mask);
  assign done_sel    = |(ext_done & sel_mask);
  assign rdata_shift = ext_rdata >> (32'(sel_q) * 32'(XLEN));

  ext_seq_timer #(
    .TIMEOUT_W(TIMEOUT_W)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (timer_clr),
    .en       (timer_en),
    .terminal (timer_term)
  );

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    arg_d       = arg_q;
    cnt_d       = cnt_q;
    need_wb_d   = need_wb_q;
    wb_data_d   = wb_data_q;
    err_d       = 1'b0;
    timer_clr   = 1'b0;
    timer_en    = 1'b0;
    timeout_evt = 1'b0;
    case (state_q)
      IDLE: begin
        if (hit && legal) begin
          sel_d     = funct3;
          arg_d     = rs1_val;
          cnt_d     = (opcode == OP_EXT_I) ? imm : 12'd1;
          need_wb_d = (opcode == OP_EXT_R);
          timer_clr = 1'b1;
          state_d   = ISSUE;
        end else if (hit) begin
          err_d = 1'b1;
        end
      end
      ISSUE: begin
        timer_en = 1'b1;
        if (accept) begin
          timer_clr = 1'b1;
          state_d   = WAIT;
        end else if (timer_term) begin
          timeout_evt = 1'b1;
          err_d       = 1'b1;
          state_d     = IDLE;
        end
      end
      WAIT: begin
        timer_en = 1'b1;
        // Completion takes priority over a timeout landing in the same cycle.
        if (done_sel) begin
          if (need_wb_q) begin
            wb_data_d = rdata_shift[XLEN-1:0];
            state_d   = WB;
          end else begin
            state_d = IDLE;
          end
        end else if (timer_term) begin
          timeout_evt = 1'b1;
          err_d       = 1'b1;
          state_d     = IDLE;
        end
      end
      WB: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      sel_q     <= '0;
      arg_q     <= '0;
      cnt_q     <= '0;
      need_wb_q <= 1'b0;
      wb_data_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      arg_q     <= arg_d;
      cnt_q     <= cnt_d;
      need_wb_q <= need_wb_d;
      wb_data_q <= wb_data_d;
      err_q     <= err_d;
    end
  end

  // Request valid is decoded from state so an async reset drops it at once.
  assign ext_req_valid = (state_q == ISSUE) ? sel_mask : '0;
  assign ext_arg       = arg_q;
  assign ext_cnt       = cnt_q;
  assign stall         = (state_q == ISSUE) || (state_q == WAIT) ||
                         ((state_q == IDLE) && hit && legal);
  assign wb_we         = (state_q == WB);
  assign wb_data       = wb_data_q;
  assign err           = err_q;
  assign busy          = (state_q != IDLE);
  assign dbg_state     = state_q;

`ifdef EXT_SEQ_PERF_EN
  logic [31:0] perf_busy_q, perf_busy_d;
  logic [15:0] perf_to_q, perf_to_d;

  always_comb begin
    perf_busy_d = perf_busy_q;
    perf_to_d   = perf_to_q;
    if (busy && !(&perf_busy_q)) begin
      perf_busy_d = perf_busy_q + 32'd1;
    end
    if (timeout_evt && !(&perf_to_q)) begin
      perf_to_d = perf_to_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_busy_q <= '0;
      perf_to_q   <= '0;
    end else begin
      perf_busy_q <= perf_busy_d;
      perf_to_q   <= perf_to_d;
    end
  end

  assign perf_busy_cycles = perf_busy_q;
  assign perf_timeouts    = perf_to_q;
`else
  logic unused_timeout;
  assign unused_timeout = timeout_evt;
`endif

endmodule

// File: tb/tb_ext_seq_controller.sv
// Randomized transaction-level bench for ext_seq_controller with a timing/result predictor.
module tb_ext_seq_controller;
  import ext_seq_pkg::*;

  localparam int NUM_EXT   = 4;
  localparam int XLEN      = 32;
  localparam int TIMEOUT_W = 4;
  // Cycles a phase may spend before the abort: counter visits 0 .. 2^W-1.
  localparam int T_LIMIT   = 1 << TIMEOUT_W;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic                    inst_valid;
  logic [4:0]              opcode;
  logic [2:0]              funct3;
  logic [XLEN-1:0]         rs1_val;
  logic [11:0]             imm;
  logic [NUM_EXT-1:0]      ext_req_valid;
  logic [NUM_EXT-1:0]      ext_req_ready;
  logic [XLEN-1:0]         ext_arg;
  logic [11:0]             ext_cnt;
  logic [NUM_EXT-1:0]      ext_done;
  logic [NUM_EXT*XLEN-1:0] ext_rdata;
  logic                    stall, wb_we, err, busy;
  logic [XLEN-1:0]         wb_data;
  state_t                  dbg_state;
`ifdef EXT_SEQ_PERF_EN
  logic [31:0]             perf_busy_cycles;
  logic [15:0]             perf_timeouts;
`endif

  int n_checks = 0;
  int n_errors = 0;
  logic [XLEN-1:0] exp_q[$];

  ext_seq_controller #(
    .NUM_EXT  (NUM_EXT),
    .XLEN     (XLEN),
    .TIMEOUT_W(TIMEOUT_W)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .inst_valid    (inst_valid),
    .opcode        (opcode),
    .funct3        (funct3),
    .rs1_val       (rs1_val),
    .imm           (imm),
    .ext_req_valid (ext_req_valid),
    .ext_req_ready (ext_req_ready),
    .ext_arg       (ext_arg),
    .ext_cnt       (ext_cnt),
    .ext_done      (ext_done),
    .ext_rdata     (ext_rdata),
    .stall         (stall),
    .wb_we         (wb_we),
    .wb_data       (wb_data),
    .err           (err),
    .busy          (busy),
    .dbg_state     (dbg_state)
`ifdef EXT_SEQ_PERF_EN
    ,
    .perf_busy_cycles(perf_busy_cycles),
    .perf_timeouts   (perf_timeouts)
`endif
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One instruction end to end. rdy_dly/done_dly index the cycle (0 = first
  // eligible) on which the channel answers; values >= T_LIMIT mean never.
  task automatic run_txn(input logic [4:0] opc, input logic [2:0] f3, input logic [31:0] rs1,
                         input logic [11:0] imm_v, input int rdy_dly, input int done_dly,
                         input bit noise, input logic [31:0] rval);
    bit is_ext, legal_m, need_wb, accepted, finished;
    logic [NUM_EXT-1:0] exp_mask;
    logic [11:0] exp_cnt;
    is_ext   = (opc == 5'b00010) || (opc == 5'b01010);
    legal_m  = (f3 >= 3'd1) && (int'(f3) <= NUM_EXT - 1);
    need_wb  = (opc == 5'b00010);
    exp_mask = NUM_EXT'(1) << f3;
    exp_cnt  = (opc == 5'b01010) ? imm_v : 12'd1;

    @(negedge clk);
    inst_valid = 1'b1; opcode = opc; funct3 = f3; rs1_val = rs1; imm = imm_v;
    ext_req_ready = '0; ext_done = '0;
    #1;
    check_eq("idle_stall", stall, is_ext && legal_m);
    check_eq("idle_busy", busy, 1'b0);
    @(negedge clk);
    inst_valid = 1'b0; opcode = 5'($urandom); funct3 = 3'($urandom);
    rs1_val = $urandom; imm = 12'($urandom);

    if (!is_ext || !legal_m) begin
      #1;
      check_eq("ign_err", err, is_ext && !legal_m);
      check_eq("ign_busy", busy, 1'b0);
      check_eq("ign_req", ext_req_valid, '0);
      check_eq("ign_stall", stall, 1'b0);
      @(negedge clk);
      #1 check_eq("err_single", err, 1'b0);
      return;
    end

    accepted = 1'b0;
    for (int i = 0; i < T_LIMIT && !accepted; i++) begin
      if (i > 0) @(negedge clk);
      if (i == rdy_dly) ext_req_ready = exp_mask | (noise ? NUM_EXT'($urandom) : '0);
      else              ext_req_ready = noise ? (NUM_EXT'($urandom) & ~exp_mask) : '0;
      #1;
      check_eq("iss_req", ext_req_valid, exp_mask);
      check_eq("iss_stall", stall, 1'b1);
      check_eq("iss_err", err, 1'b0);
      if (i == 0) begin
        check_eq("iss_arg", ext_arg, rs1);
        check_eq("iss_cnt", ext_cnt, exp_cnt);
      end
      if (i == rdy_dly) accepted = 1'b1;
    end
    @(negedge clk);
    ext_req_ready = '0;
    if (!accepted) begin
      #1;
      check_eq("iss_to_err", err, 1'b1);
      check_eq("iss_to_busy", busy, 1'b0);
      check_eq("iss_to_req", ext_req_valid, '0);
      check_eq("iss_to_we", wb_we, 1'b0);
      return;
    end

    finished = 1'b0;
    for (int i = 0; i < T_LIMIT && !finished; i++) begin
      if (i > 0) @(negedge clk);
      for (int k = 0; k < NUM_EXT; k++) ext_rdata[k*XLEN +: XLEN] = $urandom;
      if (i == done_dly) begin
        ext_rdata[int'(f3)*XLEN +: XLEN] = rval;
        ext_done = exp_mask;
        finished = 1'b1;
        if (need_wb) exp_q.push_back(rval);
      end else begin
        ext_done = noise ? (NUM_EXT'($urandom) & ~exp_mask) : '0;
      end
      #1;
      check_eq("wait_req", ext_req_valid, '0);
      check_eq("wait_stall", stall, 1'b1);
      check_eq("wait_we", wb_we, 1'b0);
      check_eq("wait_busy", busy, 1'b1);
    end
    @(negedge clk);
    ext_done = '0;
    // A new instruction offered during WB must not be taken.
    if (finished && need_wb && noise) begin
      inst_valid = 1'b1; opcode = 5'b00010; funct3 = 3'd1;
    end
    #1;
    if (!finished) begin
      check_eq("wait_to_err", err, 1'b1);
      check_eq("wait_to_busy", busy, 1'b0);
      check_eq("wait_to_we", wb_we, 1'b0);
    end else if (need_wb) begin
      check_eq("wb_we", wb_we, 1'b1);
      check_eq("wb_stall", stall, 1'b0);
      check_eq("wb_err", err, 1'b0);
      if (exp_q.size() == 0) check_eq("wb_queue", 1'b1, 1'b0);
      else check_eq("wb_data", wb_data, exp_q.pop_front());
      @(negedge clk);
      inst_valid = 1'b0;
      #1;
      check_eq("post_wb_we", wb_we, 1'b0);
      check_eq("post_wb_busy", busy, 1'b0);
    end else begin
      check_eq("imm_done_busy", busy, 1'b0);
      check_eq("imm_done_we", wb_we, 1'b0);
      check_eq("imm_done_stall", stall, 1'b0);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_busy"}, busy, 1'b0);
    check_eq({tag, "_req"}, ext_req_valid, '0);
    check_eq({tag, "_we"}, wb_we, 1'b0);
    check_eq({tag, "_err"}, err, 1'b0);
    check_eq({tag, "_wbdata"}, wb_data, '0);
    check_eq({tag, "_arg"}, ext_arg, '0);
    check_eq({tag, "_cnt"}, ext_cnt, '0);
    check_eq({tag, "_stall"}, stall, 1'b0);
  endtask

  initial begin
    logic [4:0] opc;
    logic [2:0] f3;
    int rd, dd;

    // reset
    rst_n = 1'b0; inst_valid = 1'b0; opcode = '0; funct3 = '0; rs1_val = '0; imm = '0;
    ext_req_ready = '0; ext_done = '0; ext_rdata = '0;
    #1;
    check_reset_outputs("rst");
    check_eq("rst_state", dbg_state, IDLE);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // directed cases
    run_txn(5'b00010, 3'd2, 32'hDEAD_BEEF, 12'h000, 0, 0, 1'b0, 32'h1234_5678);
    run_txn(5'b01010, 3'd1, $urandom, 12'd16, 4, 2, 1'b0, $urandom);
    run_txn(5'b00010, 3'd0, $urandom, 12'h0, 0, 0, 1'b0, $urandom);
    run_txn(5'b01010, 3'd5, $urandom, 12'h0, 0, 0, 1'b0, $urandom);
    run_txn(5'b00010, 3'd3, $urandom, 12'h0, 0, T_LIMIT, 1'b0, $urandom);
    run_txn(5'b01010, 3'd2, $urandom, 12'h7, T_LIMIT, 0, 1'b0, $urandom);
    run_txn(5'b00010, 3'd1, $urandom, 12'h0, T_LIMIT - 1, T_LIMIT - 1, 1'b0, 32'hA5A5_0F0F);
    run_txn(5'b00010, 3'd1, $urandom, 12'h0, 2, 5, 1'b1, 32'hCAFE_F00D);
    run_txn(5'b01100, 3'd2, $urandom, 12'h0, 0, 0, 1'b0, $urandom);

    // randomized traffic
    for (int n = 0; n < 150; n++) begin
      case ($urandom_range(0, 9))
        0: begin
          opc = 5'($urandom);
          if (opc == 5'b00010 || opc == 5'b01010) opc = 5'b11011;
        end
        1, 2, 3, 4: opc = 5'b00010;
        default:    opc = 5'b01010;
      endcase
      f3 = ($urandom_range(0, 5) == 0) ? 3'($urandom) : 3'($urandom_range(1, NUM_EXT - 1));
      rd = ($urandom_range(0, 9) == 0) ? $urandom_range(T_LIMIT - 1, T_LIMIT) : $urandom_range(0, 5);
      dd = ($urandom_range(0, 9) == 0) ? $urandom_range(T_LIMIT - 1, T_LIMIT) : $urandom_range(0, 6);
      run_txn(opc, f3, $urandom, 12'($urandom), rd, dd, 1'($urandom), $urandom);
    end

    // async reset in the middle of WAIT
    @(negedge clk);
    inst_valid = 1'b1; opcode = 5'b00010; funct3 = 3'd1; rs1_val = 32'h0BAD_F00D; imm = 12'h3;
    @(negedge clk);
    inst_valid = 1'b0; ext_req_ready = 4'b0010;
    @(negedge clk);
    ext_req_ready = '0;
    #1 check_eq("pre_rst_wait_busy", busy, 1'b1);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("rst_wait");
    @(negedge clk);
    rst_n = 1'b1;

    // async reset in the middle of ISSUE
    @(negedge clk);
    inst_valid = 1'b1; opcode = 5'b01010; funct3 = 3'd3;
    @(negedge clk);
    inst_valid = 1'b0;
    #1 check_eq("pre_rst_iss_req", ext_req_valid, 4'b1000);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("rst_iss");
    @(negedge clk);
    rst_n = 1'b1;

    run_txn(5'b00010, 3'd3, 32'h1111_2222, 12'h0, 1, 1, 1'b0, 32'h3333_4444);
    check_eq("exp_q_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
